// File: rtl/weight_accum_datapath.sv
// Weight accumulator: adds a loaded weight once per count strobe for N_CNT
// strobes, then pulses done and returns to idle with the result held.
module weight_accum_datapath #(
  parameter int unsigned N_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] w_in,
  input  logic       load_w_in,
  input  logic       cnt_in,
  output logic [5:0] b_out,
  output logic [5:0] s_out,
  output logic [1:0] state_out,
  output logic       done_out,
  output logic       ovf_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LP_N = 6'(N_CNT);

  state_t     r_state;
  logic [5:0] r_w;
  logic [5:0] r_b;
  logic [5:0] r_s;
  logic       r_done;
  logic       r_ovf;

  logic [6:0] w_sum;
  logic [5:0] w_s_inc;
  logic       w_last;

  // Bit 6 of the 7-bit sum is the carry out of bit 5
  assign w_sum   = {1'b0, r_b} + {1'b0, r_w};
  assign w_s_inc = r_s + 6'd1;
  assign w_last  = (w_s_inc == LP_N);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load_w_in) begin
      r_w     <= w_in;
      r_state <= S_RUN;
      r_b     <= '0;
      r_s     <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
        end
        S_RUN: begin
          r_done <= 1'b0;
          if (cnt_in) begin
            r_b   <= w_sum[5:0];
            r_s   <= w_s_inc;
            r_ovf <= r_ovf | w_sum[6];
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign b_out     = r_b;
  assign s_out     = r_s;
  assign state_out = r_state;
  assign done_out  = r_done;
  assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_weight_accum_datapath.sv
// Directed self-checking bench for weight_accum_datapath.
// Expected values are hand-derived from weight * accepted-strobe count.
module tb_weight_accum_datapath;

  logic       clk;
  logic       reset;
  logic [5:0] w_in;
  logic       load_w_in;
  logic       cnt_in;
  logic [5:0] b_out;
  logic [5:0] s_out;
  logic [1:0] state_out;
  logic       done_out;
  logic       ovf_out;

  int n_run;
  int n_fail;

  weight_accum_datapath #(.N_CNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_in      (w_in),
    .load_w_in (load_w_in),
    .cnt_in    (cnt_in),
    .b_out     (b_out),
    .s_out     (s_out),
    .state_out (state_out),
    .done_out  (done_out),
    .ovf_out   (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int b, input int s,
                         input int st, input int dn, input int ov);
    chk({tag, ".b"}, 32'(b_out), 32'(b));
    chk({tag, ".s"}, 32'(s_out), 32'(s));
    chk({tag, ".st"}, 32'(state_out), 32'(st));
    chk({tag, ".dn"}, 32'(done_out), 32'(dn));
    chk({tag, ".ov"}, 32'(ovf_out), 32'(ov));
  endtask

  task automatic load(input logic [5:0] w, input logic c);
    w_in      = w;
    load_w_in = 1'b1;
    cnt_in    = c;
    step();
    load_w_in = 1'b0;
    cnt_in    = 1'b0;
  endtask

  // n back-to-back strobes with weight w; expects DONE on the 8th total
  task automatic pulses(input string tag, input int w, input int n,
                        input int s0);
    int s;
    int b;
    int ov;
    int st;
    cnt_in = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step();
      s  = s0 + i;
      b  = (w * s) % 64;
      ov = (w * s >= 64) ? 1 : 0;
      st = (s == 8) ? 2 : 1;
      chk_all($sformatf("%s%0d", tag, i), b, s, st, (s == 8) ? 1 : 0, ov);
    end
    cnt_in = 1'b0;
  endtask

  initial begin
    logic [10:0] pat;
    int cnt;
    n_run     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    w_in      = 6'd0;
    load_w_in = 1'b0;
    cnt_in    = 1'b0;
    #1;
    chk_all("rst", 0, 0, 0, 0, 0);
    // inputs while in reset are ignored
    load_w_in = 1'b1;
    w_in      = 6'd9;
    step();
    chk_all("rst_hold", 0, 0, 0, 0, 0);
    load_w_in = 1'b0;
    #2 reset = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0, 0);
    cnt_in = 1'b1;
    step();
    chk_all("idle_cnt", 0, 0, 0, 0, 0);
    cnt_in = 1'b0;

    // w=5: 5,10,...,40
    load(6'd5, 1'b0);
    chk_all("ld5", 0, 0, 1, 0, 0);
    pulses("w5_", 5, 8, 0);
    step();
    chk_all("w5_end", 40, 8, 0, 0, 0);

    // w=63: 504 mod 64 = 56, ovf from step 2
    load(6'd63, 1'b0);
    chk_all("ld63", 0, 0, 1, 0, 0);
    pulses("w63_", 63, 8, 0);
    step();
    chk_all("w63_end", 56, 8, 0, 0, 1);

    // w=3 with gaps; 8 highs in the pattern
    load(6'd3, 1'b0);
    pat = 11'b11111011001;
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      cnt_in = pat[i];
      step();
      if (pat[i]) cnt++;
      chk_all($sformatf("gap%0d", i), 3 * cnt, cnt,
              (cnt == 8) ? 2 : 1, (cnt == 8 && pat[i]) ? 1 : 0, 0);
    end
    cnt_in = 1'b0;
    step();
    chk_all("gap_end", 24, 8, 0, 0, 0);

    // reload mid-run with cnt high in the load cycle
    load(6'd7, 1'b0);
    pulses("w7_", 7, 3, 0);
    chk("w7_b21", 32'(b_out), 32'd21);
    load(6'd2, 1'b1);
    chk_all("reld", 0, 0, 1, 0, 0);
    pulses("w2_", 2, 8, 0);
    chk("w2_b16", 32'(b_out), 32'd16);

    // W=0 still reaches DONE
    load(6'd0, 1'b0);
    pulses("w0_", 0, 8, 0);
    step();
    chk_all("w0_end", 0, 8, 0, 0, 0);

    // async reset mid-run
    load(6'd4, 1'b0);
    pulses("w4_", 4, 5, 0);
    #2 reset = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    cnt_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0);
    end
    cnt_in = 1'b0;

    // cnt ignored after DONE
    load(6'd1, 1'b0);
    pulses("w1_", 1, 8, 0);
    cnt_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("after%0d", i), 8, 8, 0, 0, 0);
    end
    cnt_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
